hack_rom_loader: RTL and testbench

//  Boot-stage front end for the Hack Computer.
//  - Receives a program as a byte stream (valid/ready) and assembles big-endian 16-bit words.
//  - Writes the words sequentially into the 32K instruction ROM.
//  - Holds the CPU in reset (active-high cpu_reset) until the whole image has loaded.
//  - Replaces $readmemb preload for synthesis and for system-level benches.

---
 rtl/hack_pkg.sv | 16 +
 rtl/hack_rom_loader_byte_pair_assembler.sv | 28 ++
 rtl/hack_rom_loader.sv | 125 ++++++++++++
 tb/tb_hack_rom_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack platform constants: ROM geometry, word width and the boot loader state encoding.
package hack_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int WORD_W     = 16;

  localparam logic [2:0] CNT_HI = 3'd0;
  localparam logic [2:0] CNT_LO = 3'd1;
  localparam logic [2:0] W_HI   = 3'd2;
  localparam logic [2:0] W_LO   = 3'd3;
  localparam logic [2:0] CS_HI  = 3'd4;
  localparam logic [2:0] CS_LO  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERR    = 3'd7;

endpackage

// File: rtl/hack_rom_loader_byte_pair_assembler.sv
// Joins a hi/lo byte pair into one big-endian word; the word is presented combinationally
// with a one-cycle word_valid on the lo-byte transfer. Phase is owned by the caller's FSM.
module byte_pair_assembler #(
  parameter int WORD_W = hack_pkg::WORD_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WORD_W/2-1:0] din,
  input  logic                take,
  input  logic                is_lo,
  output logic [WORD_W-1:0]   word,
  output logic                word_valid
);

  logic [WORD_W/2-1:0] hi_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hi_q <= '0;
    end else if (take && !is_lo) begin
      hi_q <= din;
    end
  end

  assign word       = {hi_q, din};
  assign word_valid = take & is_lo;

endmodule

// File: rtl/hack_rom_loader.sv
// Boot loader: byte stream -> sequential ROM writes, holding the CPU in reset until the image is in.
// Optional trailing XOR checksum word enabled by HACK_ROM_LOADER_CHECKSUM_EN.
module hack_rom_loader import hack_pkg::*; #(
  parameter int ADDR_W    = hack_pkg::ROM_ADDR_W,
  parameter int WORD_W    = hack_pkg::WORD_W,
  parameter int MAX_WORDS = 32768
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WORD_W/2-1:0] rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic                reload,
  output logic                rom_we,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [WORD_W-1:0]   rom_wdata,
  output logic                cpu_reset,
  output logic                done,
  output logic                error
);

  localparam logic [WORD_W:0] MAXN = (WORD_W+1)'(MAX_WORDS);

  logic [2:0]        state, state_n;
  logic [WORD_W-1:0] cnt_q, idx_q;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              xfer, is_lo, last_word, data_wr, cs_done;

  assign xfer      = rx_valid & rx_ready;
  assign is_lo     = (state == CNT_LO) || (state == W_LO) || (state == CS_LO);
  assign last_word = (idx_q + 1'b1) == cnt_q;
  assign data_wr   = word_valid && (state == W_LO);

  byte_pair_assembler #(.WORD_W(WORD_W)) u_bpa (
    .clock      (clock),
    .reset      (reset),
    .din        (rx_data),
    .take       (xfer),
    .is_lo      (is_lo),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] cs_q;
  assign cs_done = word_valid && (state == CS_LO) && (word == cs_q);
`else
  assign cs_done = 1'b0;
`endif

  always_comb begin
    state_n = state;
    if (xfer) begin
      case (state)
        CNT_HI: state_n = CNT_LO;
        CNT_LO: state_n = (word != '0 && {1'b0, word} <= MAXN) ? W_HI : ERR;
        W_HI:   state_n = W_LO;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
        W_LO:   state_n = last_word ? CS_HI : W_HI;
        CS_HI:  state_n = CS_LO;
        CS_LO:  state_n = cs_done ? DONE : ERR;
`else
        W_LO:   state_n = last_word ? DONE : W_HI;
`endif
        default: state_n = state;
      endcase
    end
  end

  // Checksum completion releases the CPU straight away; the plain path waits for DONE so
  // the release lands one cycle after the final ROM write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= CNT_HI;
      rx_ready  <= 1'b0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else if (reload) begin
      state     <= CNT_HI;
      rx_ready  <= 1'b1;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state     <= state_n;
      rx_ready  <= (state_n != DONE) && (state_n != ERR);
      rom_we    <= data_wr;
      done      <= (state == DONE) || cs_done;
      cpu_reset <= !((state == DONE) || cs_done);
      error     <= (state_n == ERR);
      if (data_wr) begin
        rom_addr  <= idx_q[ADDR_W-1:0];
        rom_wdata <= word;
        idx_q     <= idx_q + 1'b1;
      end
      if (word_valid && state == CNT_LO) begin
        cnt_q <= word;
        idx_q <= '0;
      end
    end
  end

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (!reset || reload) begin
      cs_q <= '0;
    end else if (word_valid && state == CNT_LO) begin
      cs_q <= '0;
    end else if (data_wr) begin
      cs_q <= cs_q ^ word;
    end
  end
`endif

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader: directed vectors plus randomized streams vs a stream-level model.
module tb_hack_rom_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        reload = 1'b0;
  logic        rx_ready, rom_we, cpu_reset, done, error;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;

  hack_rom_loader dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [14:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [15:0] cnt; logic exp_err; } cnt_vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   we_cyc = -1;
  int   last_xfer_cyc = -1;
  wr_t  got_q[$];
  wr_t  exp_q[$];
  logic [7:0] stream_q[$];
  logic exp_done, exp_err;
  int   exp_len;
  cnt_vec_t tbl[7];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rom_we) begin
      got_q.push_back({rom_addr, rom_wdata});
      we_cyc = cyc;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Reference: parse the byte stream by the format rules alone.
  task automatic model();
    int n;
    logic [15:0] acc, w, cs;
    exp_q.delete();
    acc = 16'h0;
    n = {stream_q[0], stream_q[1]};
    if (n == 0 || n > 32768) begin
      exp_err = 1'b1;
      exp_len = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = {stream_q[2+2*i], stream_q[3+2*i]};
        exp_q.push_back({15'(i), w});
        acc = acc ^ w;
      end
      exp_len = 2 + 2*n;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
      cs = {stream_q[exp_len], stream_q[exp_len+1]};
      exp_len += 2;
      exp_err = (cs != acc);
`else
      cs = 16'h0;
      exp_err = 1'b0;
`endif
    end
    exp_done = !exp_err;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int g, t;
    g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    repeat (g) begin
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      step();
    end
    rx_valid = 1'b1;
    rx_data = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      step();
      t++;
    end
    if (!rx_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: actual rx_ready=0 required 1 within 50 cycles");
    end else begin
      step();
      last_xfer_cyc = cyc;
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("reload.rom_we", rom_we, 0);
    chk("reload.rom_addr", rom_addr, 0);
    chk("reload.cpu_reset", cpu_reset, 1);
    chk("reload.done", done, 0);
    chk("reload.error", error, 0);
    chk("reload.rx_ready", rx_ready, 1);
  endtask

  task automatic run_stream(input string tag, input int gap_max);
    int t;
    model();
    got_q.delete();
    done_cyc = -1;
    we_cyc = -1;
    for (int i = 0; i < exp_len; i++) send_byte(stream_q[i], gap_max);
    t = 0;
    while (!(done || error) && t < 20) begin
      step();
      t++;
    end
    repeat (2) step();
    chk({tag, ".done"}, done, exp_done);
    chk({tag, ".error"}, error, exp_err);
    chk({tag, ".cpu_reset"}, cpu_reset, !exp_done);
    chk({tag, ".rx_ready"}, rx_ready, 0);
    chk({tag, ".nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk({tag, ".write"}, got_q[i], exp_q[i]);
    if (exp_done) begin
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
      chk({tag, ".release_cycle"}, done_cyc, last_xfer_cyc);
`else
      chk({tag, ".release_cycle"}, done_cyc, we_cyc + 1);
`endif
    end
  endtask

  task automatic build_stream(input logic [15:0] n, input logic bad_cs);
    logic [15:0] w, acc;
    stream_q.delete();
    acc = 16'h0;
    stream_q.push_back(n[15:8]);
    stream_q.push_back(n[7:0]);
    if (n >= 1 && n <= 16'd64) begin
      for (int i = 0; i < int'(n); i++) begin
        w = 16'($urandom);
        acc = acc ^ w;
        stream_q.push_back(w[15:8]);
        stream_q.push_back(w[7:0]);
      end
    end
    if (bad_cs) acc = acc ^ 16'(1 << $urandom_range(15, 0));
    stream_q.push_back(acc[15:8]);
    stream_q.push_back(acc[7:0]);
  endtask

  initial begin
    tbl[0] = '{16'h0000, 1'b1};
    tbl[1] = '{16'h8001, 1'b1};
    tbl[2] = '{16'hFFFF, 1'b1};
    tbl[3] = '{16'h0001, 1'b0};
    tbl[4] = '{16'h8000, 1'b0};
    tbl[5] = '{16'h7FFF, 1'b0};
    tbl[6] = '{16'h0002, 1'b0};

    // Reset
    reset = 1'b0;
    repeat (3) step();
    chk("rst.cpu_reset", cpu_reset, 1);
    chk("rst.rx_ready", rx_ready, 0);
    chk("rst.done", done, 0);
    chk("rst.error", error, 0);
    chk("rst.rom_we", rom_we, 0);
    chk("rst.rom_addr", rom_addr, 0);
    chk("rst.rom_wdata", rom_wdata, 0);
    reset = 1'b1;
    step();
    chk("rst.release_rx_ready", rx_ready, 1);

    // Basic three-word image, back-to-back bytes
    stream_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07, 8'hB9, 8'hFE};
    run_stream("basic", 0);
    chk("basic.w0", exp_q[0], {15'd0, 16'h1234});
    chk("basic.w2", exp_q[2], {15'd2, 16'h0007});
    got_q.delete();
    rx_valid = 1'b1;
    rx_data = 8'h55;
    repeat (5) step();
    rx_valid = 1'b0;
    chk("idle_valid.nwrites", got_q.size(), 0);
    chk("idle_valid.done", done, 1);

    // Count header boundaries
    for (int i = 0; i < 7; i++) begin
      do_reload();
      got_q.delete();
      send_byte(tbl[i].cnt[15:8], 0);
      send_byte(tbl[i].cnt[7:0], 0);
      chk("cnt.error", error, tbl[i].exp_err);
      chk("cnt.rx_ready", rx_ready, !tbl[i].exp_err);
      chk("cnt.cpu_reset", cpu_reset, 1);
      chk("cnt.nwrites", got_q.size(), 0);
    end

    // Gapped stream, then reload colliding with a lo-byte transfer
    do_reload();
    stream_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07, 8'hB9, 8'hFE};
    run_stream("gaps", 3);
    do_reload();
    got_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    rx_valid = 1'b1;
    rx_data = 8'hCD;
    reload = 1'b1;
    step();
    reload = 1'b0;
    rx_valid = 1'b0;
    chk("reload_mid.rom_addr", rom_addr, 0);
    chk("reload_mid.rom_we", rom_we, 0);
    chk("reload_mid.cpu_reset", cpu_reset, 1);
    chk("reload_mid.rx_ready", rx_ready, 1);
    repeat (3) step();
    chk("reload_mid.nwrites", got_q.size(), 1);
    run_stream("after_reload", 2);

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    do_reload();
    stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h00, 8'hFF, 8'h12, 8'hCB};
    run_stream("cs_good", 0);
    chk("cs_good.done_abs", done, 1);
    do_reload();
    stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h00, 8'hFF, 8'h12, 8'hCC};
    run_stream("cs_bad", 0);
    chk("cs_bad.error_abs", error, 1);
`endif

    // Reset in the middle of a load
    do_reload();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    reset = 1'b0;
    step();
    chk("midrst.rx_ready", rx_ready, 0);
    chk("midrst.cpu_reset", cpu_reset, 1);
    chk("midrst.rom_we", rom_we, 0);
    chk("midrst.rom_addr", rom_addr, 0);
    chk("midrst.rom_wdata", rom_wdata, 0);
    chk("midrst.done", done, 0);
    chk("midrst.error", error, 0);
    reset = 1'b1;
    step();
    stream_q = '{8'h00, 8'h02, 8'hBE, 8'hEF, 8'h0A, 8'h0B, 8'hB4, 8'hE4};
    run_stream("midrst.fresh", 1);

    // Randomized streams
    for (int k = 0; k < 30; k++) begin
      logic [15:0] n;
      do_reload();
      if ($urandom_range(7, 0) == 0)
        n = ($urandom_range(1, 0) == 0) ? 16'h0000 : 16'($urandom_range(65535, 32769));
      else
        n = 16'($urandom_range(12, 1));
      build_stream(n, $urandom_range(3, 0) == 0);
      run_stream("rand", $urandom_range(3, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
